pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes,
// data-memory wait stalls with a timeout trap, and stall/flush counters.
module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        ex_memr,
    input  logic [4:0]  ex_rd,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ack,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        mem_wb_bubble,
    output logic        mem_timeout,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
    output logic [1:0]  state
);

    localparam int unsigned WAIT_W = 8;
    localparam int unsigned CNT_W  = 16;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(255);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_next;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WAIT_W-1:0]   wait_next;
    logic                load_use;
    logic                stall_all;
    logic                eval_hazard;

    // Loaded value in EX feeds a source operand of the instruction in ID
    assign load_use = ex_memr && (ex_rd != 5'd0)
                      && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    assign state = state_q;

    // State, wait counter and sticky timeout flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state_q     <= state_next;
            wait_cnt    <= wait_next;
            mem_timeout <= mem_timeout || (state_next == ERROR);
        end
    end

    // Next state and stage control; branch outranks load-use once memory is quiet
    always_comb begin
        state_next    = state_q;
        wait_next     = wait_cnt;
        stall_all     = 1'b0;
        eval_hazard   = 1'b0;
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_req && !mem_ack) begin
                    stall_all  = 1'b1;
                    state_next = MEM_WAIT;
                    wait_next  = WAIT_W'(1);
                end else begin
                    eval_hazard = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!mem_ack) begin
                    stall_all = 1'b1;
                    wait_next = wait_cnt + WAIT_W'(1);
                    if (wait_cnt == WAIT_LIMIT) begin
                        state_next = ERROR;
                    end
                end else begin
                    eval_hazard = 1'b1;
                    state_next  = RUN;
                    wait_next   = '0;
                end
            end
            ERROR: begin
                stall_all = 1'b1;
            end
            default: begin
                state_next = RUN;
                wait_next  = '0;
            end
        endcase

        if (stall_all) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (eval_hazard) begin
            if (ex_branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_en && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (if_id_flush && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: inputs change at the falling edge,
// combinational outputs are checked 1 ns later, registered results at the
// following falling edge.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        ex_memr;
    logic [4:0]  ex_rd;
    logic        ex_branch_taken;
    logic        mem_req;
    logic        mem_ack;
    logic        pc_en;
    logic        if_id_en;
    logic        id_ex_en;
    logic        ex_mem_en;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        mem_wb_bubble;
    logic        mem_timeout;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic [1:0]  state;

    int total = 0;
    int bad   = 0;

    pipe_hazard_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .ex_memr         (ex_memr),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ack         (mem_ack),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .id_ex_en        (id_ex_en),
        .ex_mem_en       (ex_mem_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .mem_wb_bubble   (mem_wb_bubble),
        .mem_timeout     (mem_timeout),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .state           (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_memr = 1'b0; ex_rd = 5'd0;
        ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    // All four stage enables packed as {pc, if_id, id_ex, ex_mem}
    function automatic logic [31:0] ens();
        return 32'({pc_en, if_id_en, id_ex_en, ex_mem_en});
    endfunction

    task automatic pulse_reset();
        @(negedge clk);
        idle();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_enables", ens(), 32'hF);
        chk("rst_bubble", 32'(mem_wb_bubble), 32'd0);
        chk("rst_timeout", 32'(mem_timeout), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
        // Outputs follow RUN decoding while reset is held
        ex_memr = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3;
        #1;
        chk("rst_lu_pc_en", 32'(pc_en), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_hold_stall_cnt", 32'(stall_cnt), 32'd0);
        idle();
        reset = 1'b0;

        // Load-use: one-cycle stall, then ex_rd = 0 never stalls
        @(negedge clk);
        ex_memr = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd1; id_rs2 = 5'd5;
        #1;
        chk("lu_pc_en", 32'(pc_en), 32'd0);
        chk("lu_if_id_en", 32'(if_id_en), 32'd0);
        chk("lu_id_ex_flush", 32'(id_ex_flush), 32'd1);
        chk("lu_if_id_flush", 32'(if_id_flush), 32'd0);
        chk("lu_id_ex_en", 32'(id_ex_en), 32'd1);
        @(negedge clk);
        idle();
        #1;
        chk("lu_after_pc_en", 32'(pc_en), 32'd1);
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        @(negedge clk);
        ex_memr = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        #1;
        chk("rd0_pc_en", 32'(pc_en), 32'd1);
        chk("rd0_id_ex_flush", 32'(id_ex_flush), 32'd0);
        @(negedge clk);
        idle();
        chk("rd0_stall_cnt", 32'(stall_cnt), 32'd1);

        // Branch outranks a simultaneous load-use
        ex_branch_taken = 1'b1; ex_memr = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7;
        #1;
        chk("br_if_id_flush", 32'(if_id_flush), 32'd1);
        chk("br_id_ex_flush", 32'(id_ex_flush), 32'd1);
        chk("br_pc_en", 32'(pc_en), 32'd1);
        @(negedge clk);
        idle();
        chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("br_stall_cnt", 32'(stall_cnt), 32'd1);

        // Memory wait: 3 stalled cycles then release
        pulse_reset();
        @(negedge clk);
        mem_req = 1'b1; mem_ack = 1'b0;
        #1;
        chk("mw0_enables", ens(), 32'h0);
        chk("mw0_bubble", 32'(mem_wb_bubble), 32'd1);
        chk("mw0_state", 32'(state), 32'd0);
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("mw_enables", ens(), 32'h0);
            chk("mw_bubble", 32'(mem_wb_bubble), 32'd1);
            chk("mw_state", 32'(state), 32'd1);
        end
        @(negedge clk);
        mem_ack = 1'b1;
        #1;
        chk("mw_rel_enables", ens(), 32'hF);
        chk("mw_rel_bubble", 32'(mem_wb_bubble), 32'd0);
        @(negedge clk);
        idle();
        chk("mw_after_state", 32'(state), 32'd0);
        chk("mw_stall_cnt", 32'(stall_cnt), 32'd3);

        // Branch held during wait is acted on only in the release cycle
        pulse_reset();
        @(negedge clk);
        mem_req = 1'b1; mem_ack = 1'b0; ex_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mwbr_no_flush", 32'({if_id_flush, id_ex_flush}), 32'd0);
            @(negedge clk);
        end
        mem_ack = 1'b1;
        #1;
        chk("mwbr_rel_flush", 32'({if_id_flush, id_ex_flush}), 32'd3);
        chk("mwbr_rel_pc_en", 32'(pc_en), 32'd1);
        @(negedge clk);
        idle();
        chk("mwbr_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("mwbr_state", 32'(state), 32'd0);

        // Timeout after 256 unacknowledged cycles, sticky until reset
        pulse_reset();
        @(negedge clk);
        mem_req = 1'b1; mem_ack = 1'b0;
        for (int i = 0; i < 255; i++) @(negedge clk);
        chk("to_pre_state", 32'(state), 32'd1);
        chk("to_pre_timeout", 32'(mem_timeout), 32'd0);
        @(negedge clk);
        chk("to_state", 32'(state), 32'd2);
        chk("to_timeout", 32'(mem_timeout), 32'd1);
        mem_ack = 1'b1; ex_branch_taken = 1'b1;
        #1;
        chk("to_enables", ens(), 32'h0);
        chk("to_bubble", 32'(mem_wb_bubble), 32'd1);
        chk("to_no_flush", 32'(if_id_flush), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("to_held_state", 32'(state), 32'd2);
        chk("to_held_timeout", 32'(mem_timeout), 32'd1);
        chk("to_stall_cnt", 32'(stall_cnt), 32'd258);
        reset = 1'b1;
        #1;
        chk("to_rst_state", 32'(state), 32'd0);
        chk("to_rst_timeout", 32'(mem_timeout), 32'd0);
        chk("to_rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("to_rst_flush_cnt", 32'(flush_cnt), 32'd0);
        idle();
        #1;
        chk("to_rst_enables", ens(), 32'hF);
        reset = 1'b0;

        // Long ERROR hold saturates stall_cnt
        @(negedge clk);
        mem_req = 1'b1; mem_ack = 1'b0;
        for (int i = 0; i < 65534; i++) @(negedge clk);
        chk("sat_pre", 32'(stall_cnt), 32'd65534);
        @(negedge clk);
        chk("sat_hit", 32'(stall_cnt), 32'hFFFF);
        for (int i = 0; i < 20; i++) @(negedge clk);
        chk("sat_hold", 32'(stall_cnt), 32'hFFFF);
        chk("sat_state", 32'(state), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
